// File: rtl/obi_data_stall_injector.sv
// OBI data-port timing shim between the core and memory.
// Holds each core request for GNT_STALL cycles before forwarding it, limits
// outstanding transactions to DEPTH, and queues memory responses so that each
// one reaches the core RVALID_DELAY+1 cycles after it arrived. Response order
// and payload are preserved; delivered responses are counted.
module obi_data_stall_injector #(
    parameter int GNT_STALL    = 2,
    parameter int RVALID_DELAY = 3,
    parameter int DEPTH        = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // core side
    input  logic        s_req_i,
    output logic        s_gnt_o,
    input  logic [31:0] s_addr_i,
    input  logic        s_we_i,
    input  logic [3:0]  s_be_i,
    input  logic [31:0] s_wdata_i,
    output logic        s_rvalid_o,
    output logic [31:0] s_rdata_o,
    output logic        s_err_o,
    output logic        s_exokay_o,
    // memory side
    output logic        m_req_o,
    input  logic        m_gnt_i,
    output logic [31:0] m_addr_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i,
    input  logic        m_err_i,
    input  logic        m_exokay_i,
    // status
    output logic [31:0] txn_cnt_o,
    output logic        ovf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OUT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 32 + 1 + 1 + 5;

    localparam logic [3:0]       STALL_N   = 4'(GNT_STALL);
    localparam logic [4:0]       REL_AGE   = 5'(RVALID_DELAY);
    localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(DEPTH);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_FWD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       stall_cnt_q, stall_cnt_d;
    logic [OUT_W-1:0] outstanding_q;
    logic             credit_ok;
    logic             fwd_en;
    logic             hs;
    logic             rsp_done;

    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   fill;
    logic             fifo_empty, fifo_full;
    logic [ENT_W-1:0] in_ent, head_ent;
    logic             head_vld;
    logic [4:0]       head_age;
    logic [4:0]       now_q;
    logic             pop, push, pop_stored, drop;

    // ---------------- request gate ----------------
    // With no stall configured, IDLE behaves like FWD so a request can be
    // granted in the very cycle it appears.
    assign credit_ok = (outstanding_q < OUT_MAX);
    assign fwd_en    = (state_q == ST_FWD) || ((state_q == ST_IDLE) && (STALL_N == 4'd0));
    assign m_req_o   = fwd_en && s_req_i && credit_ok;
    assign hs        = m_req_o && m_gnt_i;
    assign s_gnt_o   = hs;

    // Attributes are stable from request to grant, so they pass straight through.
    assign m_addr_o  = s_addr_i;
    assign m_we_o    = s_we_i;
    assign m_be_o    = s_be_i;
    assign m_wdata_o = s_wdata_i;

    // Next-state logic: stall_cnt counts request cycles, the IDLE cycle included.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s_req_i) begin
                    if (STALL_N == 4'd0) begin
                        stall_cnt_d = 4'd0;
                        state_d     = hs ? ST_IDLE : ST_FWD;
                    end else if (STALL_N == 4'd1) begin
                        stall_cnt_d = 4'd1;
                        state_d     = ST_FWD;
                    end else begin
                        stall_cnt_d = 4'd1;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!s_req_i) begin
                    stall_cnt_d = 4'd0;
                    state_d     = ST_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + 4'd1;
                    if (stall_cnt_q + 4'd1 == STALL_N) begin
                        state_d = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                if (hs || !s_req_i) begin
                    stall_cnt_d = 4'd0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                stall_cnt_d = 4'd0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Gate FSM state and stall counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outstanding credit: up on grant, down on delivery to the core.
    assign rsp_done = s_rvalid_o && (outstanding_q != '0);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else if (hs && !rsp_done) begin
            outstanding_q <= outstanding_q + 1'b1;
        end else if (!hs && rsp_done) begin
            outstanding_q <= outstanding_q - 1'b1;
        end
    end

    // ---------------- response queue ----------------
    // An arriving response can be released in its own cycle when the queue is
    // empty; since the output is registered, release at age RVALID_DELAY puts
    // s_rvalid_o RVALID_DELAY+1 cycles after m_rvalid_i.
    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FIFO_FULL);
    assign in_ent     = {m_rdata_i, m_err_i, m_exokay_i, now_q};
    assign head_ent   = fifo_empty ? in_ent : fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_vld   = !fifo_empty || m_rvalid_i;
    assign head_age   = now_q - head_ent[4:0];
    assign pop        = head_vld && (head_age >= REL_AGE);
    assign push       = m_rvalid_i && !fifo_full && !(fifo_empty && pop);
    assign pop_stored = pop && !fifo_empty;
    assign drop       = m_rvalid_i && fifo_full;

    // Free-running stamp clock and queue pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            now_q    <= 5'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            now_q <= now_q + 5'd1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_stored) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Queue storage; pointers alone define validity, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= in_ent;
        end
    end

    // Registered response to the core; payload holds between beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_rvalid_o <= 1'b0;
            s_rdata_o  <= 32'd0;
            s_err_o    <= 1'b0;
            s_exokay_o <= 1'b0;
        end else begin
            s_rvalid_o <= pop;
            if (pop) begin
                s_rdata_o  <= head_ent[ENT_W-1:7];
                s_err_o    <= head_ent[6];
                s_exokay_o <= head_ent[5];
            end
        end
    end

    // Delivered-response counter and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txn_cnt_o <= 32'd0;
            ovf_o     <= 1'b0;
        end else begin
            if (pop) begin
                txn_cnt_o <= txn_cnt_o + 32'd1;
            end
            if (drop) begin
                ovf_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_data_stall_injector.sv
// Directed bench for obi_data_stall_injector. Three instances with different
// parameter sets share clock and reset; one is exercised at a time through a
// small memory model that grants immediately and answers after mem_lat cycles.
module tb_obi_data_stall_injector;

    logic clk;
    logic rst_n;

    logic        s_req [3], s_gnt [3], s_we [3], s_rvalid [3], s_err [3], s_exokay [3];
    logic        m_req [3], m_gnt [3], m_we [3], m_rvalid [3], m_err [3], m_exokay [3];
    logic        ovf [3];
    logic [31:0] s_addr [3], s_wdata [3], s_rdata [3];
    logic [31:0] m_addr [3], m_wdata [3], m_rdata [3], txn [3];
    logic [3:0]  s_be [3], m_be [3];

    // instance 0: defaults (2,3,4); instance 1: (0,0,4); instance 2: (1,15,4)
    for (genvar g = 0; g < 3; g++) begin : g_dut
        obi_data_stall_injector #(
            .GNT_STALL   (g == 0 ? 2 : (g == 1 ? 0 : 1)),
            .RVALID_DELAY(g == 0 ? 3 : (g == 1 ? 0 : 15)),
            .DEPTH       (4)
        ) u_dut (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .s_req_i   (s_req[g]),
            .s_gnt_o   (s_gnt[g]),
            .s_addr_i  (s_addr[g]),
            .s_we_i    (s_we[g]),
            .s_be_i    (s_be[g]),
            .s_wdata_i (s_wdata[g]),
            .s_rvalid_o(s_rvalid[g]),
            .s_rdata_o (s_rdata[g]),
            .s_err_o   (s_err[g]),
            .s_exokay_o(s_exokay[g]),
            .m_req_o   (m_req[g]),
            .m_gnt_i   (m_gnt[g]),
            .m_addr_o  (m_addr[g]),
            .m_we_o    (m_we[g]),
            .m_be_o    (m_be[g]),
            .m_wdata_o (m_wdata[g]),
            .m_rvalid_i(m_rvalid[g]),
            .m_rdata_i (m_rdata[g]),
            .m_err_i   (m_err[g]),
            .m_exokay_i(m_exokay[g]),
            .txn_cnt_o (txn[g]),
            .ovf_o     (ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
        logic        exo;
    } beat_t;

    beat_t       mq [$];     // pending memory responses, cyc = due cycle
    beat_t       rx [$];     // beats seen on s_rvalid, cyc = arrival cycle
    int          gnt_cyc [$];
    logic [31:0] gnt_addr [$];
    logic        gnt_we [$];
    bit          mreq_log [200];
    int          cyc;
    int          mem_lat;
    logic        mem_gnt;
    logic [31:0] err_addr;
    int          n_cmp;
    int          n_mis;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            s_req[k] = 0; s_addr[k] = '0; s_we[k] = 0; s_be[k] = '0; s_wdata[k] = '0;
            m_gnt[k] = 0; m_rvalid[k] = 0; m_rdata[k] = '0; m_err[k] = 0; m_exokay[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        mq.delete(); rx.delete(); gnt_cyc.delete(); gnt_addr.delete(); gnt_we.delete();
        foreach (mreq_log[i]) mreq_log[i] = 0;
        mem_gnt = 1'b1; mem_lat = 1; err_addr = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // One bus cycle on instance k, entered 1 time unit after a rising edge.
    task automatic mem_cycle(input int k);
        if (s_rvalid[k]) rx.push_back('{cyc, s_rdata[k], s_err[k], s_exokay[k]});
        m_rvalid[k] = 0; m_rdata[k] = '0; m_err[k] = 0; m_exokay[k] = 0;
        if (mq.size() > 0 && mq[0].cyc <= cyc) begin
            m_rvalid[k] = 1; m_rdata[k] = mq[0].data;
            m_err[k] = mq[0].err; m_exokay[k] = mq[0].exo;
            void'(mq.pop_front());
        end
        m_gnt[k] = mem_gnt;
        #1;
        if (cyc < 200) mreq_log[cyc] = m_req[k];
        if (s_gnt[k]) begin
            gnt_cyc.push_back(cyc); gnt_addr.push_back(m_addr[k]); gnt_we.push_back(m_we[k]);
            mq.push_back('{cyc + mem_lat, mem_val(m_addr[k]), m_addr[k] == err_addr,
                           m_addr[k] != err_addr});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int first;
        n_cmp = 0; n_mis = 0;

        // ---- reset state and single store, default parameters ----
        do_reset();
        check_eq("rst_s_gnt", s_gnt[0], 0);
        check_eq("rst_m_req", m_req[0], 0);
        check_eq("rst_s_rvalid", s_rvalid[0], 0);
        check_eq("rst_s_rdata", s_rdata[0], 0);
        check_eq("rst_txn", txn[0], 0);
        check_eq("rst_ovf", ovf[0], 0);
        for (int c = 0; c < 15; c++) begin
            s_req[0] = (gnt_cyc.size() == 0);
            s_addr[0] = 32'h100; s_we[0] = 1; s_be[0] = 4'hF; s_wdata[0] = 32'hCAFE_0001;
            mem_cycle(0);
        end
        first = -1;
        for (int i = 0; i < 200; i++) if (mreq_log[i] && first < 0) first = i;
        check_eq("t1_mreq_rise", first, 2);
        check_eq("t1_gnt_count", gnt_cyc.size(), 1);
        if (gnt_cyc.size() > 0) begin
            check_eq("t1_gnt_cyc", gnt_cyc[0], 2);
            check_eq("t1_m_addr", gnt_addr[0], 32'h100);
            check_eq("t1_m_we", gnt_we[0], 1);
        end
        check_eq("t1_rx_count", rx.size(), 1);
        if (rx.size() > 0) check_eq("t1_rvalid_cyc", rx[0].cyc, 7);
        check_eq("t1_txn", txn[0], 1);

        // ---- no stall, no delay: 8 back-to-back loads ----
        do_reset();
        for (int c = 0; c < 16; c++) begin
            s_req[1] = (gnt_cyc.size() < 8);
            s_addr[1] = 32'h200 + 4 * gnt_cyc.size(); s_we[1] = 0; s_be[1] = 4'hF;
            mem_cycle(1);
        end
        check_eq("t2_gnt_count", gnt_cyc.size(), 8);
        for (int i = 0; i < gnt_cyc.size() && i < 8; i++)
            check_eq($sformatf("t2_gnt%0d_cyc", i), gnt_cyc[i], i);
        check_eq("t2_rx_count", rx.size(), 8);
        for (int i = 0; i < rx.size() && i < 8; i++) begin
            check_eq($sformatf("t2_rx%0d_cyc", i), rx[i].cyc, i + 2);
            check_eq($sformatf("t2_rx%0d_data", i), rx[i].data, mem_val(32'h200 + 4 * i));
        end
        check_eq("t2_txn", txn[1], 8);

        // ---- credit limit: slow memory, 5 requests ----
        do_reset();
        mem_lat = 20;
        for (int c = 0; c < 60; c++) begin
            s_req[0] = (gnt_cyc.size() < 5);
            s_addr[0] = 32'h400 + 4 * gnt_cyc.size(); s_we[0] = 0; s_be[0] = 4'hF;
            mem_cycle(0);
        end
        check_eq("t3_gnt_count", gnt_cyc.size(), 5);
        check_eq("t3_mreq_blocked", mreq_log[20], 0);
        check_eq("t3_rx_count", rx.size(), 5);
        if (gnt_cyc.size() >= 5 && rx.size() >= 1) begin
            check_eq("t3_gnt3_cyc", gnt_cyc[3], 11);
            check_eq("t3_rx0_cyc", rx[0].cyc, 26);
            check_eq("t3_gnt5_after_rvalid", gnt_cyc[4] > rx[0].cyc, 1);
        end
        if (rx.size() >= 5) check_eq("t3_rx4_data", rx[4].data, mem_val(32'h410));
        check_eq("t3_ovf", ovf[0], 0);
        check_eq("t3_txn", txn[0], 5);

        // ---- forced overflow on the long-delay instance ----
        do_reset();
        for (int i = 0; i < 5; i++) mq.push_back('{i, 32'h1000 + i, 1'b0, 1'b0});
        for (int c = 0; c < 30; c++) begin
            mem_cycle(2);
            if (cyc == 4) check_eq("t4_ovf_pre", ovf[2], 0);
            if (cyc == 5) check_eq("t4_ovf_set", ovf[2], 1);
        end
        check_eq("t4_rx_count", rx.size(), 4);
        if (rx.size() >= 4) begin
            check_eq("t4_rx0_cyc", rx[0].cyc, 16);
            check_eq("t4_rx3_data", rx[3].data, 32'h1003);
        end
        check_eq("t4_ovf_sticky", ovf[2], 1);
        check_eq("t4_txn", txn[2], 4);

        // ---- asynchronous reset with three responses queued ----
        do_reset();
        mq.push_back('{0, 32'h2000, 1'b0, 1'b1});
        for (int i = 6; i < 9; i++) mq.push_back('{i, 32'h2001 + (i - 6), 1'b0, 1'b1});
        while (cyc < 9) mem_cycle(0);
        check_eq("t5_txn_pre", txn[0], 1);
        check_eq("t5_rdata_pre", s_rdata[0], 32'h2000);
        m_rvalid[0] = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_rvalid", s_rvalid[0], 0);
        check_eq("t5_rst_rdata", s_rdata[0], 0);
        check_eq("t5_rst_exokay", s_exokay[0], 0);
        check_eq("t5_rst_txn", txn[0], 0);
        mq.delete(); rx.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        for (int c = 0; c < 20; c++) mem_cycle(0);
        check_eq("t5_no_rvalid", rx.size(), 0);
        check_eq("t5_txn_post", txn[0], 0);

        // ---- error on the second of two loads ----
        do_reset();
        err_addr = 32'h304;
        for (int c = 0; c < 25; c++) begin
            s_req[0] = (gnt_cyc.size() < 2);
            s_addr[0] = 32'h300 + 4 * gnt_cyc.size(); s_we[0] = 0; s_be[0] = 4'hF;
            mem_cycle(0);
        end
        check_eq("t6_rx_count", rx.size(), 2);
        if (rx.size() >= 2) begin
            check_eq("t6_rx0_err", rx[0].err, 0);
            check_eq("t6_rx0_exokay", rx[0].exo, 1);
            check_eq("t6_rx1_err", rx[1].err, 1);
            check_eq("t6_rx1_exokay", rx[1].exo, 0);
            check_eq("t6_rx1_data", rx[1].data, mem_val(32'h304));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
